// File: rtl/sl_cmd_decoder.sv
// sl_cmd_decoder: consumer side of the APB command path.
// Pops {modifier,data} words from the command FIFO, updates the config,
// channel and status registers, forwards DATA words to the SL transmitter
// and pushes echoes, received words and status words into the response FIFO.
// All FIFO strobes are registered, so every strobe is high for exactly one
// cycle and lines up with the word it qualifies.
module sl_cmd_decoder #(
  parameter int         CFG_WIDTH   = 16,
  parameter int         CHAN_WIDTH  = 2,
  parameter logic [1:0] MOD_CONFIG  = 2'd0,
  parameter logic [1:0] MOD_DATA    = 2'd1,
  parameter logic [1:0] MOD_STATUS  = 2'd2,
  parameter logic [1:0] MOD_CHANNEL = 2'd3
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  // command FIFO (show-ahead read side)
  input  logic                  cmd_fifo_empty,
  input  logic [33:0]           cmd_fifo_data,
  output logic                  cmd_fifo_inc,
  // response FIFO (write side)
  input  logic                  rsp_fifo_full,
  output logic [33:0]           rsp_fifo_data,
  output logic                  rsp_fifo_inc,
  // SL transmitter
  output logic [31:0]           tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  // SL receiver
  input  logic [31:0]           rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  // register views
  output logic [CFG_WIDTH-1:0]  cfg_out,
  output logic [CHAN_WIDTH-1:0] chan_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_TX_WAIT = 2'd2;
  localparam logic [1:0] S_ECHO    = 2'd3;

  logic [1:0]            state;
  logic [33:0]           cmd_r;
  logic [CFG_WIDTH-1:0]  cfg_r;
  logic [CHAN_WIDTH-1:0] chan_r;

  // status sticky bits and the "report me" flag
  logic                  rx_ovf_r;
  logic                  rx_err_r;
  logic                  status_dirty;

  // single-entry receive buffer
  logic [31:0]           rx_buf;
  logic                  rx_full;

  // decisions made this cycle
  logic                  in_idle;
  logic                  rsp_ok;
  logic                  drain_rx;
  logic                  push_status;
  logic                  pop_cmd;
  logic                  w1c;
  logic                  ovf_set;
  logic                  ovf_nxt;
  logic                  err_nxt;
  logic                  dirty_set;
  logic [7:0]            status_vec;

  // Status byte: b0 overflow, b1 rx error, b2 transmitter busy, rest zero.
  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic err,
                                             input logic ovf);
    return {5'd0, busy, err, ovf};
  endfunction

  // Echo payload for a register-update command, zero-extended to 32 bits.
  function automatic logic [31:0] echo_word(input logic [1:0]            mod,
                                            input logic [CFG_WIDTH-1:0]  cfg,
                                            input logic [CHAN_WIDTH-1:0] chan,
                                            input logic [7:0]            status);
    logic [31:0] w;
    w = 32'd0;
    if (mod == MOD_CONFIG) begin
      w = 32'(cfg);
    end else if (mod == MOD_CHANNEL) begin
      w = 32'(chan);
    end else if (mod == MOD_STATUS) begin
      w = {24'd0, status};
    end
    return w;
  endfunction

  assign cfg_out    = cfg_r;
  assign chan_out   = chan_r;
  assign status_vec = status_byte(tx_valid, rx_err_r, rx_ovf_r);

  // Arbitrate the single IDLE action and work out next sticky/dirty values.
  // A push issued last cycle has not yet reached the full flag, so a push is
  // never issued back-to-back; this keeps the last free slot from being
  // written twice.
  always_comb begin
    in_idle     = (state == S_IDLE);
    rsp_ok      = !rsp_fifo_full && !rsp_fifo_inc;
    drain_rx    = in_idle && rx_full && rsp_ok;
    push_status = in_idle && !rx_full && status_dirty && rsp_ok;
    pop_cmd     = in_idle && !drain_rx && !push_status && !cmd_fifo_empty;
    w1c         = (state == S_DECODE) && (cmd_r[33:32] == MOD_STATUS);
    ovf_set     = rx_valid && rx_full && !drain_rx;
    // a set in the same cycle as a write-1-to-clear wins
    ovf_nxt     = ovf_set || (rx_ovf_r && !(w1c && cmd_r[0]));
    err_nxt     = rx_err  || (rx_err_r && !(w1c && cmd_r[1]));
    dirty_set   = (ovf_set && !rx_ovf_r) || (rx_err && !rx_err_r);
  end

  // Command FSM: pop, decode, transmit handshake and echo push.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state         <= S_IDLE;
      cfg_r         <= '0;
      chan_r        <= '0;
      tx_data       <= 32'd0;
      tx_valid      <= 1'b0;
      cmd_fifo_inc  <= 1'b0;
      rsp_fifo_inc  <= 1'b0;
      rsp_fifo_data <= 34'd0;
    end else begin
      cmd_fifo_inc <= 1'b0;
      rsp_fifo_inc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drain_rx) begin
            rsp_fifo_inc  <= 1'b1;
            rsp_fifo_data <= {MOD_DATA, rx_buf};
          end else if (push_status) begin
            rsp_fifo_inc  <= 1'b1;
            rsp_fifo_data <= {MOD_STATUS, 24'd0, status_vec};
          end else if (pop_cmd) begin
            cmd_fifo_inc  <= 1'b1;
            state         <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cmd_r[33:32] == MOD_CONFIG) begin
            cfg_r <= cmd_r[CFG_WIDTH-1:0];
            state <= S_ECHO;
          end else if (cmd_r[33:32] == MOD_CHANNEL) begin
            chan_r <= cmd_r[CHAN_WIDTH-1:0];
            state  <= S_ECHO;
          end else if (cmd_r[33:32] == MOD_STATUS) begin
            // sticky bits themselves are cleared in the status block
            state <= S_ECHO;
          end else begin
            tx_data  <= cmd_r[31:0];
            tx_valid <= 1'b1;
            state    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_ECHO: begin
          if (rsp_ok) begin
            rsp_fifo_inc  <= 1'b1;
            rsp_fifo_data <= {cmd_r[33:32],
                              echo_word(cmd_r[33:32], cfg_r, chan_r, status_vec)};
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch the command head word at the pop; held until the next pop.
  always_ff @(posedge pclk) begin
    if (pop_cmd) begin
      cmd_r <= cmd_fifo_data;
    end
  end

  // Sticky status bits, dirty flag and receive-buffer occupancy.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      rx_ovf_r     <= 1'b0;
      rx_err_r     <= 1'b0;
      status_dirty <= 1'b0;
      rx_full      <= 1'b0;
    end else begin
      rx_ovf_r <= ovf_nxt;
      rx_err_r <= err_nxt;
      // a fresh set must still be reported even if a status push goes out now
      if (dirty_set) begin
        status_dirty <= 1'b1;
      end else if (push_status) begin
        status_dirty <= 1'b0;
      end
      if (rx_valid && (!rx_full || drain_rx)) begin
        rx_full <= 1'b1;
      end else if (drain_rx) begin
        rx_full <= 1'b0;
      end
    end
  end

  // Receive-buffer payload: captured when empty or being drained this cycle.
  always_ff @(posedge pclk) begin
    if (rx_valid && (!rx_full || drain_rx)) begin
      rx_buf <= rx_data;
    end
  end

endmodule
